// File: rtl/seq_mult_unit.sv
// Iterative radix-2 shift-add multiplier; start accepted in IDLE, WIDTH iterations, one-cycle DONE pulse with write-back.
// Latency WIDTH edges from start to product load; start while busy is dropped, flush aborts RUN.
module seq_mult_unit #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  signed_op_i,
    input  logic [WIDTH-1:0]      op_a_i,
    input  logic [WIDTH-1:0]      op_b_i,
    input  logic [REG_ADDR_W-1:0] dest_reg_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WIDTH-1:0]      result_hi_o,
    output logic [WIDTH-1:0]      result_lo_o,
    output logic                  wb_en_o,
    output logic [REG_ADDR_W-1:0] wb_reg_o,
    output logic [WIDTH-1:0]      wb_data_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [WIDTH-1:0]      mcand_q,     mcand_d;
    logic [WIDTH-1:0]      mplier_q,    mplier_d;
    logic [WIDTH-1:0]      acc_q,       acc_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  neg_q,       neg_d;
    logic [REG_ADDR_W-1:0] dest_q,      dest_d;
    logic [WIDTH-1:0]      result_hi_q, result_hi_d;
    logic [WIDTH-1:0]      result_lo_q, result_lo_d;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_shift;
    logic [WIDTH-1:0]   mplier_shift;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;

    // Magnitudes are held unsigned, so the most negative value maps onto itself correctly.
    always_comb begin
        mag_a = (signed_op_i && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
        mag_b = (signed_op_i && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
    end

    // One iteration: conditional add into the upper half, then shift {carry, acc, multiplier} right.
    always_comb begin
        addend       = mplier_q[0] ? {1'b0, mcand_q} : '0;
        sum          = {1'b0, acc_q} + addend;
        acc_shift    = sum[WIDTH:1];
        mplier_shift = {sum[0], mplier_q[WIDTH-1:1]};
        product      = {acc_shift, mplier_shift};
        product_fix  = neg_q ? -product : product;
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        dest_d      = dest_q;
        result_hi_d = result_hi_q;
        result_lo_d = result_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_op_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
                    dest_d   = dest_reg_i;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_shift;
                    mplier_d = mplier_shift;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_hi_d = product_fix[2*WIDTH-1:WIDTH];
                        result_lo_d = product_fix[WIDTH-1:0];
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Write-back has already been issued, so flush is ignored here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            dest_q      <= '0;
            result_hi_q <= '0;
            result_lo_q <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            dest_q      <= dest_d;
            result_hi_q <= result_hi_d;
            result_lo_q <= result_lo_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign wb_en_o     = (state_q == ST_DONE);
    assign wb_reg_o    = dest_q;
    assign wb_data_o   = result_lo_q;
    assign result_hi_o = result_hi_q;
    assign result_lo_o = result_lo_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: hand-computed products, latency, ignored start, reset and flush aborts.
module tb_seq_mult_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  dest_reg;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        wb_en;
    logic [1:0]  wb_reg;
    logic [31:0] wb_data;

    int vectors     = 0;
    int miscompares = 0;

    seq_mult_unit #(.WIDTH(32), .REG_ADDR_W(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .signed_op_i (signed_op),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .dest_reg_i  (dest_reg),
        .flush_i     (flush),
        .busy_o      (busy),
        .done_o      (done),
        .result_hi_o (result_hi),
        .result_lo_o (result_lo),
        .wb_en_o     (wb_en),
        .wb_reg_o    (wb_reg),
        .wb_data_o   (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation and checks the full timeline; optionally pokes start mid-run.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] dst,
                          input logic [63:0] exp, input bit disturb);
        int dones;
        dones = 0;
        @(negedge clk);
        start = 1'b1; signed_op = sgn; op_a = a; op_b = b; dest_reg = dst;
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom; dest_reg = ~dst;
        if (done) dones++;
        for (int j = 2; j <= 32; j++) begin
            if (disturb && (j == 6 || j == 21)) begin
                start = 1'b1; op_a = 32'h0000_00FF; op_b = 32'h0000_00FF; signed_op = ~sgn;
            end
            @(negedge clk);
            if (done) dones++;
            start = 1'b0;
        end
        check({tag, "/busy_in_run"}, {63'd0, busy}, 64'd1);
        check({tag, "/early_done"}, 64'(dones), 64'd0);
        @(negedge clk);
        check({tag, "/done"}, {63'd0, done}, 64'd1);
        check({tag, "/wb_en"}, {63'd0, wb_en}, 64'd1);
        check({tag, "/wb_reg"}, {62'd0, wb_reg}, {62'd0, dst});
        check({tag, "/product"}, {result_hi, result_lo}, exp);
        check({tag, "/wb_data"}, {32'd0, wb_data}, {32'd0, exp[31:0]});
        @(negedge clk);
        check({tag, "/done_drop"}, {62'd0, done, wb_en}, 64'd0);
        check({tag, "/idle"}, {63'd0, busy}, 64'd0);
        check({tag, "/hold"}, {result_hi, result_lo}, exp);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
        dest_reg = '0; flush = 1'b0;

        #12;
        check("reset/ctrl", {61'd0, busy, done, wb_en}, 64'd0);
        check("reset/result", {result_hi, result_lo}, 64'd0);
        check("reset/wb", {30'd0, wb_reg, wb_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u3x5",    1'b0, 32'd3,         32'd5,         2'd1, 64'h0000_0000_0000_000F, 1'b0);
        run_op("uFFxFF",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op("u_shift", 1'b0, 32'h1234_5678, 32'h0000_0010, 2'd2, 64'h0000_0001_2345_6780, 1'b0);
        run_op("s_m1x2",  1'b1, 32'hFFFF_FFFF, 32'd2,         2'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("s_minsq", 1'b1, 32'h8000_0000, 32'h8000_0000, 2'd1, 64'h4000_0000_0000_0000, 1'b0);
        run_op("s_minx1", 1'b1, 32'h8000_0000, 32'd1,         2'd2, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_op("s_m3x7",  1'b1, 32'hFFFF_FFFD, 32'd7,         2'd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op("s_0xm5",  1'b1, 32'd0,         32'hFFFF_FFFB, 2'd1, 64'h0000_0000_0000_0000, 1'b0);
        run_op("busy_st", 1'b0, 32'd6,         32'd7,         2'd2, 64'h0000_0000_0000_002A, 1'b1);

        // Reset in the middle of a run discards it.
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; op_a = 32'd9; op_b = 32'd9; dest_reg = 2'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid/ctrl", {61'd0, busy, done, wb_en}, 64'd0);
        check("rst_mid/result", {result_hi, result_lo}, 64'd0);
        check("rst_mid/wb", {30'd0, wb_reg, wb_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (done || wb_en) dones++;
        end
        check("rst_mid/no_done", 64'(dones), 64'd0);
        run_op("after_rst", 1'b0, 32'd10, 32'd10, 2'd1, 64'h0000_0000_0000_0064, 1'b0);

        // Flush in RUN aborts and keeps the previous product.
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; op_a = 32'h0000_FFFF; op_b = 32'h0000_FFFF; dest_reg = 2'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush/ctrl", {61'd0, busy, done, wb_en}, 64'd0);
        check("flush/hold", {result_hi, result_lo}, 64'h0000_0000_0000_0064);
        dones = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done || wb_en || busy) dones++;
        end
        check("flush/no_done", 64'(dones), 64'd0);

        // Flush together with start in IDLE suppresses the start.
        start = 1'b1; flush = 1'b1; op_a = 32'd2; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start/idle", {63'd0, busy}, 64'd0);
        dones = 0;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("flush_start/no_run", 64'(dones), 64'd0);
        check("flush_start/hold", {result_hi, result_lo}, 64'h0000_0000_0000_0064);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
